// File: rtl/ram_dump_uart.sv
// Sweeps a RAM address range and streams each word as uppercase ASCII hex over 8N1 UART, CR LF every WORDS_PER_LINE words.
// First start bit 3 cycles after start; no backpressure, start is ignored while a dump is in progress.
module ram_dump_uart #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int CLKS_PER_BIT   = 434,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int DIGITS = DATA_WIDTH / 4;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int LC_W   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, SEP, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic                  sep_q, sep_d;
    logic [3:0]            bit_q, bit_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LC_W-1:0]       line_q, line_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  last_bit, last_word, eol, eol_n;
    logic [7:0]            byte_n;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nibble(input logic [DATA_WIDTH-1:0] w, input logic [DIG_W-1:0] d);
        logic [DATA_WIDTH-1:0] sh;
        sh = w >> (4 * (DIGITS - 1 - int'(d)));
        return sh[3:0];
    endfunction

    // Frame bit 0 is the start bit, 1..8 data LSB first, 9 stop; 10 is the inter-word setup cycle.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [7:0] sh;
        sh = b >> (idx - 4'd1);
        if (idx == 4'd0) return 1'b0;
        if (idx <= 4'd8) return sh[0];
        return 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        end_addr_d = end_addr_q;
        word_d     = word_q;
        digit_d    = digit_q;
        sep_d      = sep_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        last_bit   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        last_word  = (ram_addr_q == end_addr_q);
        eol        = last_word || (line_q == LC_W'(WORDS_PER_LINE - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    ram_addr_d = start_addr;
                    end_addr_d = end_addr;
                    line_d     = '0;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                word_d  = ram_q;
                digit_d = '0;
                sep_d   = 1'b0;
                bit_d   = 4'd0;
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (!last_bit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (bit_q != 4'd9) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d = 4'd0;
                        if (digit_q == DIG_W'(DIGITS - 1)) state_d = SEP;
                        else                               digit_d = digit_q + DIG_W'(1);
                    end
                end
            end
            SEP: begin
                if (bit_q == 4'd10) begin
                    state_d    = FETCH;
                    ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
                    line_d     = eol ? '0 : line_q + LC_W'(1);
                end else if (!last_bit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (bit_q != 4'd9) begin
                        bit_d = bit_q + 4'd1;
                    end else if (eol && !sep_q) begin
                        sep_d = 1'b1;
                        bit_d = 4'd0;
                    end else if (last_word) begin
                        state_d = DONE;
                    end else begin
                        bit_d = 4'd10;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // tx is registered, so the line level is derived from the next-cycle state.
        eol_n  = (ram_addr_d == end_addr_d) || (line_d == LC_W'(WORDS_PER_LINE - 1));
        byte_n = (state_d == SEP) ? (eol_n ? (sep_d ? 8'h0A : 8'h0D) : 8'h20)
                                  : hex_char(nibble(word_d, digit_d));
        tx_d   = (state_d == SEND || state_d == SEP) ? frame_bit(byte_n, bit_d) : 1'b1;
        busy_d = (state_d == FETCH) || (state_d == LATCH) || (state_d == SEND) || (state_d == SEP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            end_addr_q <= '0;
            word_q     <= '0;
            digit_q    <= '0;
            sep_q      <= 1'b0;
            bit_q      <= 4'd0;
            cnt_q      <= '0;
            line_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            end_addr_q <= end_addr_d;
            word_q     <= word_d;
            digit_q    <= digit_d;
            sep_q      <= sep_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_ram_dump_uart.sv
// Directed and randomized dumps against a byte/waveform reference model built from the word list.
module tb_ram_dump_uart;
    localparam int DW = 16, AW = 10, CPB = 4, WPL = 8;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] start_addr, end_addr, ram_addr;
    logic [DW-1:0] ram_q;
    logic          tx, busy, done;

    always #5 clk = ~clk;

    ram_dump_uart #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .ram_addr(ram_addr), .ram_q(ram_q), .tx(tx), .busy(busy), .done(done)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) ram_q <= mem[ram_addr];

    int    checks = 0, errors = 0;
    string tname;

    logic          tr_tx[$], tr_busy[$], tr_done[$];
    logic [AW-1:0] tr_addr[$];
    int            done_cyc, done_cnt;

    logic          exp_tx[$];
    logic [7:0]    exp_bytes[$];
    int            exp_ws[$];
    logic [AW-1:0] exp_wa[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0d expected=%0d", tname, tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_bytes.push_back(b);
        repeat (CPB) exp_tx.push_back(1'b0);
        for (int j = 0; j < 8; j++) repeat (CPB) exp_tx.push_back(b[j]);
        repeat (CPB) exp_tx.push_back(1'b1);
    endtask

    task automatic build_model(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        logic [AW-1:0] diff, a;
        int            n, nib;
        exp_tx.delete(); exp_bytes.delete(); exp_ws.delete(); exp_wa.delete();
        diff = ea - sa;
        n    = int'(diff) + 1;
        repeat (3) exp_tx.push_back(1'b1);
        for (int w = 0; w < n; w++) begin
            a = sa + AW'(w);
            if (w > 0) repeat (3) exp_tx.push_back(1'b1);
            exp_ws.push_back(exp_tx.size());
            exp_wa.push_back(a);
            for (int c = 0; c < DW / 4; c++) begin
                nib = (int'(mem[a]) >> (4 * (DW / 4 - 1 - c))) & 15;
                push_byte(8'((nib < 10) ? (48 + nib) : (55 + nib)));
            end
            if (w == n - 1 || (w + 1) % WPL == 0) begin
                push_byte(8'h0D);
                push_byte(8'h0A);
            end else begin
                push_byte(8'h20);
            end
        end
    endtask

    // poke_kind: 0 none, 1 second start with (psa,pea), 2 reset pulse.
    task automatic run(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int poke_cyc,
                       input int poke_kind, input logic [AW-1:0] psa, input logic [AW-1:0] pea);
        tr_tx.delete(); tr_busy.delete(); tr_done.delete(); tr_addr.delete();
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk);
        for (int k = 0; k < 6000; k++) begin
            tr_tx.push_back(tx); tr_busy.push_back(busy); tr_done.push_back(done); tr_addr.push_back(ram_addr);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            start = (k == 0) || (poke_kind == 1 && k == poke_cyc);
            reset = (poke_kind == 2 && k == poke_cyc);
            if (k == 0) begin
                start_addr = sa; end_addr = ea;
            end else if (poke_kind == 1 && k == poke_cyc) begin
                start_addr = psa; end_addr = pea;
            end
            if ((poke_kind == 2) ? (k == poke_cyc + 20) : (done_cyc >= 0)) break;
            @(negedge clk);
        end
    endtask

    task automatic analyze(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        int    exp_done, fs, bad_w, bad_b, bad_a;
        logic  b;
        logic [7:0] d;
        string dec_hex, exp_hex;
        build_model(sa, ea);
        exp_done = exp_tx.size();
        chk("done_cycle", done_cyc, exp_done);
        chk("done_count", done_cnt, 1);
        b = (tr_busy.size() > exp_done) ? tr_busy[exp_done] : 1'bx;
        chk("busy_at_done", b, 0);
        chk("addr_cycle1", (tr_addr.size() > 1) ? tr_addr[1] : 'x, sa);
        fs = -1;
        for (int c = 0; c < tr_tx.size(); c++) if (fs < 0 && tr_tx[c] === 1'b0) fs = c;
        chk("first_start", fs, 3);
        bad_w = 0; bad_b = 0; bad_a = 0;
        for (int c = 0; c < exp_done; c++) begin
            if (c >= tr_tx.size() || tr_tx[c] !== exp_tx[c]) bad_w++;
            if (c >= 1 && (c >= tr_busy.size() || tr_busy[c] !== 1'b1)) bad_b++;
        end
        for (int i = 0; i < exp_ws.size(); i++)
            if (exp_ws[i] >= tr_addr.size() || tr_addr[exp_ws[i]] !== exp_wa[i]) bad_a++;
        chk("tx_wave_bad_cycles", bad_w, 0);
        chk("busy_low_cycles", bad_b, 0);
        chk("ram_addr_bad_words", bad_a, 0);
        dec_hex = ""; exp_hex = "";
        for (int i = 0; i + 10 * CPB <= tr_tx.size(); ) begin
            if (tr_tx[i] === 1'b0) begin
                for (int j = 0; j < 8; j++) d[j] = tr_tx[i + CPB * (j + 1) + CPB / 2];
                dec_hex = $sformatf("%s%02x", dec_hex, d);
                i += 10 * CPB;
            end else begin
                i++;
            end
        end
        foreach (exp_bytes[i]) exp_hex = $sformatf("%s%02x", exp_hex, exp_bytes[i]);
        checks++;
        assert (dec_hex == exp_hex) else begin
            errors++;
            $error("FAIL %s/bytes observed=%s expected=%s", tname, dec_hex, exp_hex);
        end
    endtask

    initial begin
        int            bad;
        logic [AW-1:0] sa, ea;
        reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

        tname = "reset";
        repeat (3) @(negedge clk);
        chk("tx", tx, 1); chk("busy", busy, 0); chk("done", done, 0); chk("ram_addr", ram_addr, 0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== '0) bad++;
        end
        chk("idle_100", bad, 0);

        tname = "beef";
        mem[0] = 16'hBEEF;
        run(0, 0, -1, 0, 0, 0);
        chk("done_243", done_cyc, 243);
        analyze(0, 0);

        tname = "nine_words";
        for (int i = 0; i < 9; i++) mem[i] = DW'(i + 1);
        run(0, 8, -1, 0, 0, 0);
        analyze(0, 8);

        tname = "wrap";
        run(10'h3FF, 10'h000, -1, 0, 0, 0);
        analyze(10'h3FF, 10'h000);

        tname = "restart_ignored";
        run(10'h100, 10'h102, 50, 1, 10'h200, 10'h201);
        analyze(10'h100, 10'h102);
        tname = "fresh_after_done";
        run(10'h200, 10'h201, -1, 0, 0, 0);
        analyze(10'h200, 10'h201);

        tname = "mid_reset";
        run(10'h010, 10'h012, 63, 2, 0, 0);
        chk("busy_before", tr_busy[63], 1);
        chk("tx_after", tr_tx[64], 1);
        chk("busy_after", tr_busy[64], 0);
        chk("addr_after", tr_addr[64], 0);
        chk("no_done", done_cnt, 0);
        bad = 0;
        for (int c = 64; c < tr_tx.size(); c++) if (tr_tx[c] !== 1'b1 || tr_busy[c] !== 1'b0) bad++;
        chk("quiet_after", bad, 0);
        tname = "after_reset";
        run(10'h010, 10'h012, -1, 0, 0, 0);
        analyze(10'h010, 10'h012);

        for (int r = 0; r < 3; r++) begin
            tname = $sformatf("random%0d", r);
            sa = AW'($urandom);
            ea = sa + AW'($urandom_range(0, 11));
            for (logic [AW-1:0] a = sa; ; a++) begin
                mem[a] = DW'($urandom);
                if (a == ea) break;
            end
            run(sa, ea, -1, 0, 0, 0);
            analyze(sa, ea);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
